collatz_responder: RTL and testbench

COLLATZ_RESPONDER -- requirements
Module: collatz_responder

---
 rtl/collatz_if.sv | 23 ++
 rtl/collatz_responder.sv | 98 +++++++++
 tb/tb_collatz_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/collatz_if.sv
// Request/response bundle for the Collatz step-count responder.
// Handshake: read is a one-cycle strobe sampled at a rising edge (accepted only while busy=0);
// write pulses for one cycle with b/err valid, and b/err are held until the next result.
interface collatz_if #(
  parameter int N = 27
);
  logic         read;
  logic [N-1:0] a;
  logic         write;
  logic [N-1:0] b;
  logic         err;
  logic         busy;

  modport master (
    output read, a,
    input  write, b, err, busy
  );

  modport slave (
    input  read, a,
    output write, b, err, busy
  );
endinterface

// File: rtl/collatz_responder.sv
// Counts Collatz steps of an operand down to 1, one step per clock.
// Reports all-ones with err=1 when 3x+1 or the step counter would exceed N bits.
module collatz_responder #(
  parameter int N = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  collatz_if.slave   bus,
  output logic       dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] b_q, b_d;
  logic         err_q, err_d;
  logic         write_q, write_d;

  // Two guard bits hold 3x+1 without loss so overflow is a plain compare.
  logic [N+1:0] x3p1;
  logic [N+1:0] n_max;

  assign x3p1  = ({2'b00, x_q} << 1) + {2'b00, x_q} + {{(N+1){1'b0}}, 1'b1};
  assign n_max = {2'b00, {N{1'b1}}};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    err_d   = err_q;
    write_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read) begin
          x_d     = bus.a;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (x_q <= {{(N-1){1'b0}}, 1'b1}) begin
          b_d     = cnt_q;
          err_d   = 1'b0;
          write_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == {N{1'b1}}) begin
          b_d     = '1;
          err_d   = 1'b1;
          write_d = 1'b1;
          state_d = IDLE;
        end else if (!x_q[0]) begin
          x_d   = x_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end else if (x3p1 > n_max) begin
          b_d     = '1;
          err_d   = 1'b1;
          write_d = 1'b1;
          state_d = IDLE;
        end else begin
          x_d   = x3p1[N-1:0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      err_q   <= err_d;
      write_q <= write_d;
    end
  end

  assign bus.write   = write_q;
  assign bus.b       = b_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q == RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_collatz_responder.sv
// Bench for collatz_responder: directed scenarios plus random operands scored
// against an arithmetic Collatz model.
module tb_collatz_responder;
  localparam int N = 27;
  localparam longint NMAX = (longint'(1) << N) - 1;

  logic clk;
  logic rst_n;
  logic dbg_state;

  collatz_if #(.N(N)) bus ();

  collatz_responder #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  int reqs_done = 0;
  logic [N:0] exp_q[$];

  always @(negedge clk) if (bus.write) writes_seen++;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Collatz model: steps until x reaches 1, or error on N-bit overflow.
  function automatic void ref_model(input longint a, output logic [N-1:0] b,
                                    output logic e, output int steps);
    longint x;
    longint cnt;
    x = a;
    cnt = 0;
    e = 1'b0;
    while (x > 1) begin
      if (cnt == NMAX) begin
        e = 1'b1;
        break;
      end
      if (x % 2 == 0) x = x / 2;
      else if (3 * x + 1 > NMAX) begin
        e = 1'b1;
        break;
      end else x = 3 * x + 1;
      cnt++;
    end
    b = e ? N'(NMAX) : N'(cnt);
    steps = int'(cnt);
  endfunction

  // Drive read for one edge (caller is idle, #1 after an edge); leaves us #1 after accept.
  task automatic start_req(input logic [N-1:0] op, output int steps);
    logic [N-1:0] eb;
    logic ee;
    ref_model(longint'(op), eb, ee, steps);
    bus.read = 1'b1;
    bus.a = op;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    exp_q.push_back({ee, eb});
    check("busy_after_accept", longint'(bus.busy), 1);
  endtask

  // Wait for write; result latency is steps+1 edges after the accept edge.
  task automatic collect(input int steps, input int already);
    int edges;
    logic [N:0] exp;
    edges = already;
    while (!bus.write && edges < steps + 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!bus.write) begin
      check("write_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    reqs_done++;
    check("latency", edges, steps + 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
      return;
    end
    exp = exp_q.pop_front();
    check("result_b", longint'(bus.b), longint'(exp[N-1:0]));
    check("result_err", longint'(bus.err), longint'(exp[N]));
    check("busy_at_write", longint'(bus.busy), 0);
  endtask

  task automatic finish_write();
    logic [N-1:0] held;
    held = bus.b;
    @(posedge clk);
    #1;
    check("write_one_cycle", longint'(bus.write), 0);
    check("b_held", longint'(bus.b), longint'(held));
  endtask

  task automatic run_req(input logic [N-1:0] op);
    int s;
    start_req(op, s);
    collect(s, 0);
    finish_write();
  endtask

  initial begin
    int s;
    int s2;
    int busy_cycles;
    int w0;
    bus.read = 1'b0;
    bus.a = '0;
    rst_n = 1'b0;
    #1;
    check("reset_write", longint'(bus.write), 0);
    check("reset_b", longint'(bus.b), 0);
    check("reset_err", longint'(bus.err), 0);
    check("reset_busy", longint'(bus.busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: a=6, busy for 9 cycles, b=8 (read offered at the first edge after reset)
    start_req(N'(6), s);
    busy_cycles = 1;
    while (bus.busy && busy_cycles < 50) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cycles++;
    end
    check("s1_busy_cycles", busy_cycles, 9);
    collect(s, busy_cycles);
    check("s1_b_const", longint'(bus.b), 8);
    finish_write();

    // Scenario 2: a=27 -> b=111
    run_req(N'(27));
    check("s2_b_const", longint'(bus.b), 111);

    // Scenario 3: a=1 then a=0
    run_req(N'(1));
    check("s3_a1_b", longint'(bus.b), 0);
    run_req(N'(0));
    check("s3_a0_b", longint'(bus.b), 0);

    // Scenario 4: all-ones operand overflows on the first step
    run_req(N'(NMAX));
    check("s4_err", longint'(bus.err), 1);
    check("s4_b", longint'(bus.b), NMAX);

    // Scenario 5: read while busy is ignored; read in the write cycle is accepted
    start_req(N'(6), s);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.read = 1'b1;
    bus.a = N'(3);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    check("s5_busy_ignored", longint'(bus.busy), 1);
    collect(s, 4);
    check("s5_first_b", longint'(bus.b), 8);
    start_req(N'(3), s2);
    check("s5_write_dropped", longint'(bus.write), 0);
    collect(s2, 0);
    check("s5_second_b", longint'(bus.b), 7);
    finish_write();

    // Scenario 6: reset mid-run aborts the request
    w0 = writes_seen;
    start_req(N'(27), s);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("s6_rst_write", longint'(bus.write), 0);
    check("s6_rst_busy", longint'(bus.busy), 0);
    check("s6_rst_b", longint'(bus.b), 0);
    check("s6_rst_err", longint'(bus.err), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    check("s6_no_write", writes_seen - w0, 0);
    run_req(N'(6));

    // Random operands, mixing small values with full-width ones
    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] op;
      if (i % 3 == 0) op = N'($urandom_range(0, 32'(NMAX)));
      else op = N'($urandom_range(0, 5000));
      run_req(op);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    check("write_count", writes_seen, reqs_done);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
